load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access initiator between the datapath and the word-addressed, synchronous-read data memory.
- Accepts byte/halfword/word load and store requests with byte addresses.
- Drives the memory's Address/WriteData/MemRead/MemWrite and consumes its registered ReadData.
- Performs sign/zero extension on loads and read-modify-write for sub-word stores, signalling completion with a one-cycle Done pulse.

Parameters:
- NUM_SLOTS, 32, memory depth in words; word addresses >= NUM_SLOTS are errors.
- DATA_WIDTH, 32, word width; fixed at 32 for this revision.

Ports:
- Clk  input  1  clock, all state on posedge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  1  request strobe, sampled only in IDLE.
- IsStore  input  1  1 = store, 0 = load.
- Size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- Signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- Addr  input  32  byte address.
- StoreData  input  32  store data, right-aligned for sub-word stores.
- Busy  output  1  high in every non-IDLE state.
- Done  output  1  registered one-cycle completion pulse.
- Error  output  1  registered; valid only with Done.
- LoadData  output  32  registered load result; holds until the next load completes.
- MemAddress  output  32  word address, {2'b00, Addr[31:2]}.
- MemWriteData  output  32  word written to memory.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable.
- MemReadData  input  32  memory ReadData, valid the cycle after MemRead.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: state = IDLE; Busy, Done, Error, MemRead, MemWrite = 0; LoadData, MemAddress, MemWriteData = 0; capture registers = 0.
- Endianness: little-endian lanes. Byte lane k = Addr[1:0], bits [8k+7:8k]. Half lane h = Addr[1], bits [16h+15:16h].
- States: IDLE, RD, EXT, MERGE, WR.
- IDLE, Req=1 at edge E0:
  - Capture Addr, Size, Signed, IsStore and StoreData.
  - Check for errors: Size=11; half with Addr[0]=1; word with Addr[1:0]!=0; Addr[31:2] >= NUM_SLOTS.
  - On error: Done=1 and Error=1 in the cycle after E0, remain in IDLE, MemRead/MemWrite never asserted.
  - Otherwise: load -> RD; word store -> WR; sub-word store -> RD.
- RD: MemRead=1 for exactly one cycle. Next state is EXT for a load, MERGE for a store.
- EXT: extract the lane from MemReadData, extend per Signed, register LoadData, Done=1, go to IDLE.
  - Load latency: Done high in the cycle after E2 (3rd cycle after the accepting edge).
- MERGE: replace the addressed lane of MemReadData with StoreData[7:0] or [15:0], register the result into MemWriteData, go to WR.
- WR: MemWrite=1 for exactly one cycle. MemWriteData is the captured StoreData (word store) or the merged word. Done=1 on exit, go to IDLE.
  - Word-store latency: Done in the cycle after E1.
  - Sub-word-store latency: Done in the cycle after E3.
- Mutual exclusion: MemRead and MemWrite are never high in the same cycle.
- Address stability: MemAddress is stable for the whole transaction.
- Req while Busy: ignored, no queuing.
- Back-to-back: Req in the Done cycle (state IDLE) is accepted.
- Error and Done: Error clears when Done deasserts. LoadData is unchanged on error and on stores.
- Reset mid-operation: state -> IDLE on that edge; no MemRead/MemWrite afterwards; no Done for the aborted transaction; a pending sub-word store never writes.

Decomposition:
- Shared package:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD.
  - FSM state enum.
  - Word-address-shift constant (2).
- One sub-module, lane_extract_merge (combinational):
  - Inputs: word, offset[1:0], Size, Signed, StoreData.
  - Outputs: extended load value, merged store word.

Test Plan:
- Bench memory model preloads word 8 = 0xDEAD_DAD5. Load byte signed, Addr 0x23 -> LoadData 0xFFFF_FFDE, Error=0, Done in the 3rd cycle after accept, exactly one MemRead cycle with MemAddress 8.
- Load half unsigned, Addr 0x22 -> 0x0000_DEAD. Load half signed, Addr 0x20 -> 0xFFFF_DAD5. Load word, Addr 0x20 -> 0xDEAD_DAD5.
- Store byte, Addr 0x21, StoreData 0x0000_00AA:
  - One MemRead, then one MemWrite with 0xDEAD_AAD5.
  - Word 8 then reads 0xDEAD_AAD5.
- Store word, Addr 0x50, StoreData 0x1234_5678:
  - MemRead never asserted, one MemWrite to word 20.
  - Done the cycle after E1.
  - A Req during Busy is ignored.
- Error cases, each giving Done=Error=1 the cycle after accept with no memory enables:
  - Load word at 0x22.
  - Load half at 0x21.
  - Size=11.
  - Addr 0x80 (word 32 >= NUM_SLOTS).
- Reset during MERGE of store byte to 0x24 -> no MemWrite, word 9 unchanged, all outputs 0 next cycle, and a new Req is accepted normally afterwards.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: size encodings, FSM states and address shift shared by the load/store unit
package load_store_unit_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  localparam int ADDR_SHIFT = 2;
  typedef enum logic [2:0] {IDLE, RD, EXT, MERGE, WR} state_t;
endpackage

// File: rtl/load_store_unit_lane_extract_merge.sv
// lane_extract_merge: little-endian lane extraction with extension, and sub-word merge into a word
module lane_extract_merge
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] store_data,
  output logic [31:0] load_value,
  output logic [31:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{offset, 3'b000} +: 8];
    h = word[{offset[1], 4'b0000} +: 16];
    load_value = size == SZ_BYTE ? {{24{sign_ext & b[7]}}, b} :
                 size == SZ_HALF ? {{16{sign_ext & h[15]}}, h} : word;
    merged = word;
    if (size == SZ_BYTE) merged[{offset, 3'b000} +: 8] = store_data[7:0];
    else if (size == SZ_HALF) merged[{offset[1], 4'b0000} +: 16] = store_data[15:0];
    else merged = store_data;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store initiator for a synchronous-read word-addressed memory
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int NUM_SLOTS  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Req,
  input  logic                  IsStore,
  input  logic [1:0]            Size,
  input  logic                  Signed,
  input  logic [31:0]           Addr,
  input  logic [DATA_WIDTH-1:0] StoreData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic [DATA_WIDTH-1:0] LoadData,
  output logic [31:0]           MemAddress,
  output logic [DATA_WIDTH-1:0] MemWriteData,
  output logic                  MemRead,
  output logic                  MemWrite,
  input  logic [DATA_WIDTH-1:0] MemReadData
);
  state_t      state;
  logic [1:0]  cap_off, cap_size;
  logic        cap_signed, cap_store;
  logic [31:0] cap_data, word_addr, ext_value, merged_word;
  logic        bad;
  assign word_addr = Addr >> ADDR_SHIFT;
  assign bad = Size == SZ_RSVD || (Size == SZ_HALF && Addr[0]) ||
               (Size == SZ_WORD && Addr[1:0] != 2'b00) || word_addr >= 32'(NUM_SLOTS);
  lane_extract_merge u_lem (
    .word(MemReadData), .offset(cap_off), .size(cap_size), .sign_ext(cap_signed),
    .store_data(cap_data), .load_value(ext_value), .merged(merged_word)
  );
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      Busy <= 1'b0;
      Done <= 1'b0;
      Error <= 1'b0;
      MemRead <= 1'b0;
      MemWrite <= 1'b0;
      LoadData <= '0;
      MemAddress <= '0;
      MemWriteData <= '0;
      cap_off <= '0;
      cap_size <= '0;
      cap_signed <= 1'b0;
      cap_store <= 1'b0;
      cap_data <= '0;
    end else begin
      Done <= 1'b0;
      Error <= 1'b0;
      MemRead <= 1'b0;
      MemWrite <= 1'b0;
      case (state)
        IDLE: if (Req) begin
          cap_off <= Addr[1:0];
          cap_size <= Size;
          cap_signed <= Signed;
          cap_store <= IsStore;
          cap_data <= StoreData;
          MemAddress <= word_addr;
          if (bad) begin
            Done <= 1'b1;
            Error <= 1'b1;
          end else if (IsStore && Size == SZ_WORD) begin
            state <= WR;
            Busy <= 1'b1;
            MemWrite <= 1'b1;
            MemWriteData <= StoreData;
          end else begin
            state <= RD;
            Busy <= 1'b1;
            MemRead <= 1'b1;
          end
        end
        RD: state <= cap_store ? MERGE : EXT;
        EXT: begin
          LoadData <= ext_value;
          Done <= 1'b1;
          Busy <= 1'b0;
          state <= IDLE;
        end
        MERGE: begin
          MemWriteData <= merged_word;
          MemWrite <= 1'b1;
          state <= WR;
        end
        WR: begin
          Done <= 1'b1;
          Busy <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against a cycle-schedule model of the load/store unit
module tb_load_store_unit;
  logic        Clk = 1'b0, Reset = 1'b1, Req = 1'b0, IsStore = 1'b0, Signed = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic [31:0] Addr = '0, StoreData = '0, MemReadData = '0;
  logic        Busy, Done, Error, MemRead, MemWrite;
  logic [31:0] LoadData, MemAddress, MemWriteData;
  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  int n_vec = 0, n_bad = 0;
  int cyc = 0, start_at = -1, done_at = -1, rd_at = -1, wr_at = -1, busy_until = 0;
  logic        exp_err = 1'b0, ld = 1'b0;
  logic [31:0] exp_load = '0, pend_load = '0, wr_val = '0, exp_addr = '0;

  load_store_unit #(.NUM_SLOTS(32), .DATA_WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .IsStore(IsStore), .Size(Size), .Signed(Signed),
    .Addr(Addr), .StoreData(StoreData), .Busy(Busy), .Done(Done), .Error(Error),
    .LoadData(LoadData), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemReadData(MemReadData)
  );

  always #5 Clk = ~Clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Memory with registered read data, one cycle after MemRead
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[8] = 32'hDEAD_DAD5;
    mem[9] = 32'h0BAD_F00D;
    forever begin
      @(posedge Clk);
      if (MemWrite) mem[MemAddress[4:0]] = MemWriteData;
      if (MemRead) MemReadData = mem[MemAddress[4:0]];
    end
  end

  // Model: schedule each accepted request by its documented latency; values by plain arithmetic
  function automatic void accept(int n0);
    logic [31:0] w, word, v, mask;
    int off, lat;
    w = Addr >> 2;
    off = int'(Addr & 32'h3);
    exp_err = Size == 2'b11 || (Size == 2'b01 && Addr[0]) || (Size == 2'b10 && off != 0) || w >= 32;
    if (exp_err) begin
      start_at = n0; done_at = n0; busy_until = n0; rd_at = -1; wr_at = -1; ld = 1'b0;
      return;
    end
    word = ref_mem[w[4:0]];
    lat = !IsStore ? 2 : Size == 2'b10 ? 1 : 3;
    start_at = n0;
    done_at = n0 + lat;
    busy_until = done_at;
    rd_at = (IsStore && Size == 2'b10) ? -1 : n0;
    wr_at = IsStore ? n0 + lat - 1 : -1;
    exp_addr = w;
    ld = !IsStore;
    if (Size == 2'b00) begin
      v = (word >> (8 * off)) & 32'hFF;
      if (Signed && v[7]) v = v | 32'hFFFF_FF00;
      mask = 32'hFF << (8 * off);
      wr_val = (word & ~mask) | ((StoreData << (8 * off)) & mask);
    end else if (Size == 2'b01) begin
      v = (word >> (16 * (off / 2))) & 32'hFFFF;
      if (Signed && v[15]) v = v | 32'hFFFF_0000;
      mask = 32'hFFFF << (16 * (off / 2));
      wr_val = (word & ~mask) | ((StoreData << (16 * (off / 2))) & mask);
    end else begin
      v = word;
      wr_val = StoreData;
    end
    pend_load = v;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    ref_mem[8] = 32'hDEAD_DAD5;
    ref_mem[9] = 32'h0BAD_F00D;
    forever begin
      @(posedge Clk);
      if (cyc == wr_at) ref_mem[exp_addr[4:0]] = wr_val;
      if (Reset) begin
        start_at = -1; done_at = -1; rd_at = -1; wr_at = -1; busy_until = 0; exp_load = '0; ld = 1'b0;
      end else if (Req && cyc >= busy_until) accept(cyc + 1);
      cyc++;
      if (cyc == done_at && ld) exp_load = pend_load;
    end
  end

  // Compare process
  initial begin
    forever begin
      @(negedge Clk);
      if (cyc > 0) begin
        check("done", {31'b0, Done}, {31'b0, cyc == done_at});
        check("error", {31'b0, Error}, {31'b0, cyc == done_at && exp_err});
        check("busy", {31'b0, Busy}, {31'b0, cyc >= start_at && cyc < done_at && !exp_err});
        check("memread", {31'b0, MemRead}, {31'b0, cyc == rd_at});
        check("memwrite", {31'b0, MemWrite}, {31'b0, cyc == wr_at});
        check("loaddata", LoadData, exp_load);
        if (cyc >= start_at && cyc < done_at && !exp_err) check("memaddress", MemAddress, exp_addr);
        if (MemWrite) check("memwritedata", MemWriteData, wr_val);
      end
    end
  end

  task automatic run(input logic st, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                     input logic [31:0] sd, input int lat, input logic err);
    int k;
    IsStore = st; Size = sz; Signed = sg; Addr = a; StoreData = sd; Req = 1'b1;
    @(posedge Clk);
    #1 Req = 1'b0;
    k = 0;
    do begin
      @(negedge Clk);
      k++;
    end while (!Done && k < 10);
    check("latency", k, lat);
    check("error_literal", {31'b0, Error}, {31'b0, err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    check("reset_busy", {31'b0, Busy}, 32'd0);
    check("reset_loaddata", LoadData, 32'h0);
    check("reset_memaddress", MemAddress, 32'h0);
    run(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 3, 1'b0);
    check("lb_signed", LoadData, 32'hFFFF_FFDE);
    run(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 3, 1'b0);
    check("lh_unsigned", LoadData, 32'h0000_DEAD);
    run(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 3, 1'b0);
    check("lh_signed", LoadData, 32'hFFFF_DAD5);
    run(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 3, 1'b0);
    check("lw", LoadData, 32'hDEAD_DAD5);
    run(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00AA, 4, 1'b0);
    check("sb_mem8", mem[8], 32'hDEAD_AAD5);
    check("sb_loaddata_kept", LoadData, 32'hDEAD_DAD5);
    run(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 3, 1'b0);
    check("lw_after_sb", LoadData, 32'hDEAD_AAD5);
    // Word store with Req held into the WR cycle, where it must be ignored
    IsStore = 1'b1; Size = 2'b10; Addr = 32'h50; StoreData = 32'h1234_5678; Req = 1'b1;
    @(posedge Clk);
    #1 IsStore = 1'b0; Addr = 32'h20;
    @(posedge Clk);
    #1 Req = 1'b0;
    check("sw_done", {31'b0, Done}, 32'd1);
    check("sw_mem20", mem[20], 32'h1234_5678);
    @(posedge Clk);
    #1 check("sw_busy_req_ignored", {31'b0, Busy}, 32'd0);
    run(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1, 1'b1);
    run(1'b0, 2'b01, 1'b1, 32'h21, 32'h0, 1, 1'b1);
    run(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1, 1'b1);
    run(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1, 1'b1);
    run(1'b1, 2'b00, 1'b0, 32'h83, 32'h55, 1, 1'b1);
    check("err_loaddata_kept", LoadData, 32'hDEAD_AAD5);
    // Reset while a byte store sits in MERGE
    IsStore = 1'b1; Size = 2'b00; Addr = 32'h24; StoreData = 32'h55; Req = 1'b1;
    @(posedge Clk);
    #1 Req = 1'b0;
    @(posedge Clk);
    #1 Reset = 1'b1;
    check("merge_busy", {31'b0, Busy}, 32'd1);
    @(posedge Clk);
    #1 Reset = 1'b0;
    check("rst_outputs", {Busy, Done, Error, MemRead, MemWrite}, 32'd0);
    check("rst_loaddata", LoadData, 32'h0);
    check("rst_memaddress", MemAddress, 32'h0);
    check("rst_memwritedata", MemWriteData, 32'h0);
    repeat (3) @(posedge Clk);
    #1 check("rst_mem9", mem[9], 32'h0BAD_F00D);
    run(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 3, 1'b0);
    check("lw_after_reset", LoadData, 32'h0BAD_F00D);
    run(1'b1, 2'b01, 1'b0, 32'h26, 32'h0000_BEEF, 4, 1'b0);
    run(1'b0, 2'b00, 1'b0, 32'h27, 32'h0, 3, 1'b0);
    check("lbu_after_sh", LoadData, 32'h0000_00BE);
    @(posedge Clk);
    #1;
    for (int i = 0; i < 32; i++) check("mem_image", mem[i], ref_mem[i]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
